// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch program counter with branch/jump/call/return, exception vector and RAS
//
// Holds the fetch PC and picks the next one each rising edge. Priority, highest first:
// Reset, Exception, Stall, Return, Jump (Call also pushes), BranchTaken, sequential.
// Lower-priority requests in the same cycle are dropped.
//
// Ports:
//   Clk           in   clock, rising edge
//   Reset         in   synchronous active-high reset
//   Stall         in   hold PC and RAS state
//   BranchTaken   in   redirect to BranchTarget
//   BranchTarget  in   [ADDR_WIDTH]
//   Jump          in   redirect to JumpTarget
//   Call          in   with Jump: push PCResult+INC
//   JumpTarget    in   [ADDR_WIDTH]
//   Return        in   pop RAS (or use ReturnTarget when empty)
//   ReturnTarget  in   [ADDR_WIDTH] fallback target
//   Exception     in   redirect to EXC_VECTOR, capture EPC
//   PCResult      out  current fetch PC
//   PCPlusInc     out  PCResult+INC, combinational
//   EPC           out  PC captured at last exception
//   RasCount      out  number of valid RAS entries
//   RasUnderflow  out  sticky: Return with empty RAS

module pc_unit #(
    parameter int unsigned              ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0]    RESET_VECTOR = '0,
    parameter logic [ADDR_WIDTH-1:0]    EXC_VECTOR   = ADDR_WIDTH'(32'h80000180),
    parameter int unsigned              INC          = 4,
    parameter int unsigned              RAS_DEPTH    = 4
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           Stall,
    input  logic                           BranchTaken,
    input  logic [ADDR_WIDTH-1:0]          BranchTarget,
    input  logic                           Jump,
    input  logic                           Call,
    input  logic [ADDR_WIDTH-1:0]          JumpTarget,
    input  logic                           Return,
    input  logic [ADDR_WIDTH-1:0]          ReturnTarget,
    input  logic                           Exception,
    output logic [ADDR_WIDTH-1:0]          PCResult,
    output logic [ADDR_WIDTH-1:0]          PCPlusInc,
    output logic [ADDR_WIDTH-1:0]          EPC,
    output logic [$clog2(RAS_DEPTH):0]     RasCount,
    output logic                           RasUnderflow
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] epc_q, epc_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  unf_q, unf_d;
    logic                  push;
    logic [ADDR_WIDTH-1:0] pc_plus_inc;
    logic [ADDR_WIDTH-1:0] ras_top;
    logic [ADDR_WIDTH-1:0] ras_q [RAS_DEPTH];

    // Modulo-2^ADDR_WIDTH add; wrap past all-ones is silent.
    assign pc_plus_inc = pc_q + ADDR_WIDTH'(INC);
    // Pointer is a write pointer, so the newest entry lives one below it.
    // RAS_DEPTH is a power of two, so the pointer arithmetic wraps for free.
    assign ras_top     = ras_q[ptr_q - PTR_W'(1)];

    always_comb begin
        pc_d  = pc_q;
        epc_d = epc_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        unf_d = unf_q;
        push  = 1'b0;
        if (Exception) begin
            pc_d  = EXC_VECTOR;
            epc_d = pc_q;
        end else if (Stall) begin
            pc_d = pc_q;
        end else if (Return) begin
            if (cnt_q != '0) begin
                pc_d  = ras_top;
                ptr_d = ptr_q - PTR_W'(1);
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                pc_d  = ReturnTarget;
                unf_d = 1'b1;
            end
        end else if (Jump) begin
            pc_d = JumpTarget;
            if (Call) begin
                push  = 1'b1;
                ptr_d = ptr_q + PTR_W'(1);
                // Full stack: the push overwrites the oldest entry, count saturates.
                if (cnt_q != CNT_W'(RAS_DEPTH)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end else if (BranchTaken) begin
            pc_d = BranchTarget;
        end else begin
            pc_d = pc_plus_inc;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q  <= RESET_VECTOR;
            epc_q <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            unf_q <= unf_d;
        end
    end

    // Entry storage has no reset; only pointer and count define validity.
    always_ff @(posedge Clk) begin
        if (!Reset && push) begin
            ras_q[ptr_q] <= pc_plus_inc;
        end
    end

    assign PCResult     = pc_q;
    assign PCPlusInc    = pc_plus_inc;
    assign EPC          = epc_q;
    assign RasCount     = cnt_q;
    assign RasUnderflow = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - scoreboard bench for pc_unit with directed vectors

module tb_pc_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0, Stall = 1'b0, BranchTaken = 1'b0, Jump = 1'b0;
    logic        Call = 1'b0, Return = 1'b0, Exception = 1'b0;
    logic [31:0] BranchTarget = '0, JumpTarget = '0, ReturnTarget = '0;
    logic [31:0] PCResult, PCPlusInc, EPC;
    logic [2:0]  RasCount;
    logic        RasUnderflow;

    pc_unit dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .Jump(Jump), .Call(Call), .JumpTarget(JumpTarget),
        .Return(Return), .ReturnTarget(ReturnTarget),
        .Exception(Exception),
        .PCResult(PCResult), .PCPlusInc(PCPlusInc), .EPC(EPC),
        .RasCount(RasCount), .RasUnderflow(RasUnderflow)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic [2:0]  cnt;
        logic        unf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Control word bits: {Reset, Exception, Stall, Return, Jump, Call, BranchTaken}
    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] RS = 7'b1000000;
    localparam logic [6:0] EX = 7'b0100000;
    localparam logic [6:0] ST = 7'b0010000;
    localparam logic [6:0] RT = 7'b0001000;
    localparam logic [6:0] JP = 7'b0000100;
    localparam logic [6:0] CL = 7'b0000010;
    localparam logic [6:0] BR = 7'b0000001;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: apply inputs at the falling edge and queue what must appear after the next rise.
    task automatic step(input logic [6:0] ctl, input logic [31:0] tgt,
                        input logic [31:0] pc, input logic [31:0] epc,
                        input logic [2:0] cnt, input logic unf);
        exp_t e;
        @(negedge Clk);
        {Reset, Exception, Stall, Return, Jump, Call, BranchTaken} = ctl;
        BranchTarget = tgt;
        JumpTarget   = tgt;
        ReturnTarget = tgt;
        e.pc = pc; e.epc = epc; e.cnt = cnt; e.unf = unf;
        sb.push_back(e);
    endtask

    // Monitor: outputs settle shortly after each rising edge.
    initial begin
        exp_t e;
        logic [31:0] inc_exp;
        forever begin
            @(posedge Clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                inc_exp = e.pc + 32'd4;
                check("PCResult", PCResult, e.pc);
                check("PCPlusInc", PCPlusInc, inc_exp);
                check("EPC", EPC, e.epc);
                check("RasCount", {29'd0, RasCount}, {29'd0, e.cnt});
                check("RasUnderflow", {31'd0, RasUnderflow}, {31'd0, e.unf});
            end
        end
    end

    initial begin
        // 1: reset then sequential
        step(RS,   32'h0, 32'h0,  32'h0, 3'd0, 1'b0);
        step(RS,   32'h0, 32'h0,  32'h0, 3'd0, 1'b0);
        step(NONE, 32'h0, 32'h4,  32'h0, 3'd0, 1'b0);
        step(NONE, 32'h0, 32'h8,  32'h0, 3'd0, 1'b0);
        step(NONE, 32'h0, 32'hC,  32'h0, 3'd0, 1'b0);
        step(NONE, 32'h0, 32'h10, 32'h0, 3'd0, 1'b0);
        // 2: stall masks branch, then branch taken
        step(ST|BR, 32'h40, 32'h10, 32'h0, 3'd0, 1'b0);
        step(BR,    32'h40, 32'h40, 32'h0, 3'd0, 1'b0);
        // 3: two calls, two returns
        step(JP,    32'h20,  32'h20,  32'h0, 3'd0, 1'b0);
        step(JP|CL, 32'h100, 32'h100, 32'h0, 3'd1, 1'b0);
        step(NONE,  32'h0,   32'h104, 32'h0, 3'd1, 1'b0);
        step(JP|CL, 32'h200, 32'h200, 32'h0, 3'd2, 1'b0);
        step(RT,    32'h0,   32'h108, 32'h0, 3'd1, 1'b0);
        step(RT,    32'h0,   32'h24,  32'h0, 3'd0, 1'b0);
        // 4: five nested calls overflow a depth-4 stack, then underflow
        step(JP|CL, 32'h1000, 32'h1000, 32'h0, 3'd1, 1'b0);
        step(JP|CL, 32'h2000, 32'h2000, 32'h0, 3'd2, 1'b0);
        step(JP|CL, 32'h3000, 32'h3000, 32'h0, 3'd3, 1'b0);
        step(JP|CL, 32'h4000, 32'h4000, 32'h0, 3'd4, 1'b0);
        step(JP|CL, 32'h5000, 32'h5000, 32'h0, 3'd4, 1'b0);
        step(RT, 32'hDEAD0000, 32'h4004,     32'h0, 3'd3, 1'b0);
        step(RT, 32'hDEAD0000, 32'h3004,     32'h0, 3'd2, 1'b0);
        step(RT, 32'hDEAD0000, 32'h2004,     32'h0, 3'd1, 1'b0);
        step(RT, 32'hDEAD0000, 32'h1004,     32'h0, 3'd0, 1'b0);
        step(RT, 32'hDEAD0000, 32'hDEAD0000, 32'h0, 3'd0, 1'b1);
        step(NONE, 32'h0, 32'hDEAD0004, 32'h0, 3'd0, 1'b1);
        // Call without Jump is ignored
        step(CL,   32'h700, 32'hDEAD0008, 32'h0, 3'd0, 1'b1);
        // 5: exception beats stall/jump/return, RAS untouched
        step(JP|CL,       32'h3C,  32'h3C,       32'h0,  3'd1, 1'b1);
        step(EX|ST|JP|RT, 32'h500, 32'h80000180, 32'h3C, 3'd1, 1'b1);
        step(ST,          32'h0,   32'h80000180, 32'h3C, 3'd1, 1'b1);
        step(RT,          32'h900, 32'hDEAD000C, 32'h3C, 3'd0, 1'b1);
        // 6: wrap, then reset in a call chain
        step(JP,    32'hFFFFFFFC, 32'hFFFFFFFC, 32'h3C, 3'd0, 1'b1);
        step(NONE,  32'h0,   32'h0,   32'h3C, 3'd0, 1'b1);
        step(NONE,  32'h0,   32'h4,   32'h3C, 3'd0, 1'b1);
        step(JP|CL, 32'h600, 32'h600, 32'h3C, 3'd1, 1'b1);
        step(JP|CL, 32'h700, 32'h700, 32'h3C, 3'd2, 1'b1);
        step(JP|CL, 32'h800, 32'h800, 32'h3C, 3'd3, 1'b1);
        step(RS|EX|JP|CL, 32'h900, 32'h0, 32'h0, 3'd0, 1'b0);
        step(NONE,  32'h0,   32'h4,   32'h0, 3'd0, 1'b0);
        step(RT,    32'h900, 32'h900, 32'h0, 3'd0, 1'b1);
        step(NONE,  32'h0,   32'h904, 32'h0, 3'd0, 1'b1);

        @(negedge Clk);
        {Reset, Exception, Stall, Return, Jump, Call, BranchTaken} = NONE;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge Clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised successor to the lab-1 program counter.
- Holds the fetch PC and selects the next PC from these sources: sequential increment, branch, jump, call/return, exception vector.
- Supports fetch stall.
- Keeps a small circular return-address stack (RAS) for call/return.
- Captures the faulting PC into an EPC register on exception.
- Sits at the head of the fetch stage and drives instruction-memory address.

Parameters:
ADDR_WIDTH, 32, width of PC, targets and RAS entries
RESET_VECTOR, 32'h00000000, PC value loaded on reset
EXC_VECTOR, 32'h80000180, PC value loaded on exception
INC, 4, sequential increment in bytes
RAS_DEPTH, 4, return-address stack entries (power of 2, >=2)

Ports:
Clk  input  1  clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Stall  input  1  hold PC and RAS this cycle
BranchTaken  input  1  take BranchTarget
BranchTarget  input  ADDR_WIDTH  branch destination
Jump  input  1  take JumpTarget
Call  input  1  qualifies Jump: also push return address
JumpTarget  input  ADDR_WIDTH  jump/call destination
Return  input  1  pop RAS, jump to popped address
ReturnTarget  input  ADDR_WIDTH  fallback target (register value) when RAS empty
Exception  input  1  redirect to EXC_VECTOR, capture EPC
PCResult  output  ADDR_WIDTH  current fetch PC
PCPlusInc  output  ADDR_WIDTH  PCResult+INC, combinational
EPC  output  ADDR_WIDTH  PC captured at last exception
RasCount  output  $clog2(RAS_DEPTH)+1  valid RAS entries
RasUnderflow  output  1  sticky: Return seen with RAS empty

Behaviour:

Reset (synchronous, active-high):
- PCResult=RESET_VECTOR, EPC=0, RasCount=0, RasUnderflow=0.
- RAS pointer=0; RAS contents are don't-care.
- Reset overrides every other input in the same cycle.

Next-PC latency:
- Every redirect takes effect on the next rising edge: one cycle.
- No delay slots and no bubbles are generated.

Priority per edge, highest first:
1. Reset
2. Exception: PCResult<=EXC_VECTOR, EPC<=PCResult. RAS unchanged. Ignores Stall.
3. Stall: PCResult, RAS, RasCount and RasUnderflow all hold.
4. Return:
   - RasCount>0: PCResult<=top entry, pointer decrements, RasCount-1.
   - RasCount==0: PCResult<=ReturnTarget, RasUnderflow<=1.
5. Jump:
   - PCResult<=JumpTarget.
   - If Call=1, push PCResult+INC onto the RAS.
6. BranchTaken: PCResult<=BranchTarget.
7. Otherwise: PCResult<=PCResult+INC.

Masking rules:
- Lower-priority requests in the same cycle are discarded, not queued.
- Call without Jump has no effect.

Arithmetic:
- All additions are modulo 2^ADDR_WIDTH.
- All-ones-aligned PC + INC wraps to 0 with no flag.
- Targets are used unmodified; no alignment check.

RAS structure and boundaries:
- Circular buffer with a write pointer.
- Push writes at the pointer, then increments it mod RAS_DEPTH.
- Pop reads at pointer-1, then decrements it.
- RasCount saturates at RAS_DEPTH.
- Push when full overwrites the oldest entry; RasCount stays RAS_DEPTH.
- After DEPTH+1 calls, DEPTH returns yield the newest DEPTH addresses. A further return then underflows.

Sticky flag and EPC:
- RasUnderflow clears only on Reset.
- EPC changes only on Exception or Reset.

Test Plan:
1. Reset held 2 cycles, then released for 3 cycles → PCResult=0 during reset, then 4, 8, 12. PCPlusInc tracks at 4, 8, 12, 16.
2. At PC=0x10, assert BranchTaken with BranchTarget=0x40 and Stall=1 for 1 cycle, then Stall=0 → PC holds at 0x10, then becomes 0x40.
3. Jump+Call to 0x100 at PC=0x20, then Jump+Call to 0x200 at PC=0x104, then Return twice → PC sequence 0x100, 0x200, 0x108, 0x24. RasCount goes 1, 2, 1, 0.
4. With RAS_DEPTH=4, make 5 nested calls returning to A1..A5, then 5 Returns with ReturnTarget=0xDEAD0000 → pops A5, A4, A3, A2, then PC=0xDEAD0000 and RasUnderflow=1. RasUnderflow stays 1 until Reset.
5. At PC=0x3C, assert Exception together with Stall, Jump and Return → PCResult=0x80000180, EPC=0x3C, RasCount unchanged.
6. Load PC=0xFFFFFFFC via Jump, then run sequentially → next PC=0x00000000 with no other side effect. Then assert Reset mid-call-chain with RasCount=3 → PC=RESET_VECTOR, RasCount=0, EPC=0.
